// File: rtl/celement_pkg.sv
// Shared types and helpers for the clocked C-element branch stages.
package celement_pkg;

    localparam int MAX_N_BRANCH = 16;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SEND,
        ACKHI
    } state_e;

    // Never returns 0, so a select port always has at least one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/celement_senddelay.sv
// Loadable down-counter with hold and zero flag for clocked C-element stages.
module celement_senddelay #(
    parameter int DLYW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            hold,
    input  logic [DLYW-1:0] load_val,
    output logic            zero
);

    logic [DLYW-1:0] cnt_q;
    logic [DLYW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (!hold && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/celement_branch_n.sv
// Clocked N-way C-element branch: one four-phase input, N four-phase outputs.
// Define CELEM_BRANCH_PROTCHK_EN to add the sticky ERR protocol-check output.
module celement_branch_n
    import celement_pkg::*;
#(
    parameter int N_BRANCH   = 2,
    parameter int SEND_DELAY = 1,
    parameter int DLYW       = 8,
    localparam int SELW      = sel_width(N_BRANCH)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                SENDIN,
    input  logic [SELW-1:0]     BRIN,
    input  logic                LOPEN,
    input  logic [N_BRANCH-1:0] ACKIN,
    output logic [N_BRANCH-1:0] SENDOUT,
    output logic                ACKOUT,
    output logic                CP,
    output logic                BUSY
`ifdef CELEM_BRANCH_PROTCHK_EN
    ,
    output logic                ERR
`endif
);

    localparam logic [SELW-1:0] BR_MAX = SELW'(N_BRANCH - 1);
    localparam logic [DLYW-1:0] LOAD_VAL =
        (SEND_DELAY > 0) ? DLYW'(SEND_DELAY - 1) : '0;

    function automatic logic [N_BRANCH-1:0] onehot(input logic [SELW-1:0] s);
        return {{(N_BRANCH-1){1'b0}}, 1'b1} << s;
    endfunction

    state_e              state_q, state_d;
    logic [SELW-1:0]     br_q, br_d;
    logic [N_BRANCH-1:0] sendout_q, sendout_d;
    logic                ackout_q, ackout_d;
    logic                cp_q, cp_d;
    logic                busy_q, busy_d;

    logic                brin_oor;
    logic [SELW-1:0]     brin_sat;
    logic [N_BRANCH-1:0] dec_q;
    logic                ack_sel;
    logic                accept;
    logic                cnt_load;
    logic                cnt_hold;
    logic                cnt_zero;

    assign brin_oor = (BRIN > BR_MAX);
    assign brin_sat = brin_oor ? BR_MAX : BRIN;
    assign dec_q    = onehot(br_q);
    assign ack_sel  = |(ACKIN & dec_q);
    assign accept   = (state_q == IDLE) && SENDIN && LOPEN;
    assign cnt_hold = !((state_q == DELAY) && LOPEN);

    always_comb begin
        state_d  = state_q;
        br_d     = br_q;
        ackout_d = ackout_q;
        cp_d     = 1'b0;
        cnt_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    br_d = brin_sat;
                    cp_d = 1'b1;
                    if (SEND_DELAY == 0) begin
                        state_d = SEND;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = DELAY;
                    end
                end
            end
            DELAY: begin
                if (LOPEN && cnt_zero) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (LOPEN && ack_sel) begin
                    ackout_d = 1'b1;
                    state_d  = ACKHI;
                end
            end
            ACKHI: begin
                if (!SENDIN && !ack_sel) begin
                    ackout_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // LOPEN gates the request one cycle later without leaving SEND.
        sendout_d = ((state_d == SEND) && LOPEN) ? onehot(br_d) : '0;
        busy_d    = (state_d != IDLE);
    end

    celement_senddelay #(
        .DLYW(DLYW)
    ) u_senddelay (
        .clk     (CLK),
        .rst     (RESET),
        .load    (cnt_load),
        .hold    (cnt_hold),
        .load_val(LOAD_VAL),
        .zero    (cnt_zero)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            br_q      <= '0;
            sendout_q <= '0;
            ackout_q  <= 1'b0;
            cp_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            br_q      <= br_d;
            sendout_q <= sendout_d;
            ackout_q  <= ackout_d;
            cp_q      <= cp_d;
            busy_q    <= busy_d;
        end
    end

    assign SENDOUT = sendout_q;
    assign ACKOUT  = ackout_q;
    assign CP      = cp_q;
    assign BUSY    = busy_q;

`ifdef CELEM_BRANCH_PROTCHK_EN
    logic err_q, err_d;
    logic sendin_q, sendin_d;
    logic sendin_fall;

    assign sendin_fall = sendin_q && !SENDIN &&
                         ((state_q == DELAY) || (state_q == SEND));

    always_comb begin
        sendin_d = SENDIN;
        err_d    = err_q
                 | (busy_q && |(ACKIN & ~dec_q))
                 | (accept && brin_oor)
                 | sendin_fall;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err_q    <= 1'b0;
            sendin_q <= 1'b0;
        end else begin
            err_q    <= err_d;
            sendin_q <= sendin_d;
        end
    end

    assign ERR = err_q;
`endif

endmodule

// File: tb/tb_celement_branch_n.sv
// Scoreboard bench: stimulus queues expected output changes, a monitor checks them.
module tb_celement_branch_n;

`ifdef CELEM_BRANCH_PROTCHK_EN
    localparam logic PC = 1'b1;
`else
    localparam logic PC = 1'b0;
`endif

    typedef struct {
        int         k;
        int         cyc;
        logic [7:0] v;
        string      nm;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;
    int   cyc = 0;
    int   nchk = 0;
    int   nbad = 0;
    logic mon_en = 1'b0;
    exp_t sbq[$];
    exp_t me;
    logic [7:0] prev[3] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] cur[3];

    // u0: N=4, delay 2
    logic       SENDIN0, LOPEN0, ACKOUT0, CP0, BUSY0, err0;
    logic [1:0] BRIN0;
    logic [3:0] ACKIN0, SENDOUT0;
    // u1: N=2, delay 0, driven by a reactive environment
    logic       auto1, LOPEN1, ACKOUT1, CP1, BUSY1, err1, SENDIN1;
    logic [0:0] BRIN1;
    logic [1:0] ACKIN1, SENDOUT1;
    // u2: N=3, delay 1
    logic       SENDIN2, LOPEN2, ACKOUT2, CP2, BUSY2, err2;
    logic [1:0] BRIN2;
    logic [2:0] ACKIN2, SENDOUT2;

    assign SENDIN1 = auto1 & ~ACKOUT1;
    assign ACKIN1  = auto1 ? SENDOUT1 : 2'b00;

    celement_branch_n #(.N_BRANCH(4), .SEND_DELAY(2)) u0 (
        .CLK(CLK), .RESET(RESET), .SENDIN(SENDIN0), .BRIN(BRIN0),
        .LOPEN(LOPEN0), .ACKIN(ACKIN0), .SENDOUT(SENDOUT0),
        .ACKOUT(ACKOUT0), .CP(CP0), .BUSY(BUSY0)
`ifdef CELEM_BRANCH_PROTCHK_EN
        , .ERR(err0)
`endif
    );

    celement_branch_n #(.N_BRANCH(2), .SEND_DELAY(0)) u1 (
        .CLK(CLK), .RESET(RESET), .SENDIN(SENDIN1), .BRIN(BRIN1),
        .LOPEN(LOPEN1), .ACKIN(ACKIN1), .SENDOUT(SENDOUT1),
        .ACKOUT(ACKOUT1), .CP(CP1), .BUSY(BUSY1)
`ifdef CELEM_BRANCH_PROTCHK_EN
        , .ERR(err1)
`endif
    );

    celement_branch_n #(.N_BRANCH(3), .SEND_DELAY(1)) u2 (
        .CLK(CLK), .RESET(RESET), .SENDIN(SENDIN2), .BRIN(BRIN2),
        .LOPEN(LOPEN2), .ACKIN(ACKIN2), .SENDOUT(SENDOUT2),
        .ACKOUT(ACKOUT2), .CP(CP2), .BUSY(BUSY2)
`ifdef CELEM_BRANCH_PROTCHK_EN
        , .ERR(err2)
`endif
    );

`ifndef CELEM_BRANCH_PROTCHK_EN
    assign err0 = 1'b0;
    assign err1 = 1'b0;
    assign err2 = 1'b0;
`endif

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] sv(input logic e, input logic b,
                                      input logic c, input logic a,
                                      input logic [3:0] so);
        return {e, b, c, a, so};
    endfunction

    task automatic push(input int k, input int c, input logic [7:0] v,
                        input string nm);
        exp_t x;
        x.k = k; x.cyc = c; x.v = v; x.nm = nm;
        sbq.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] want);
        nchk++;
        if (got !== want) begin
            nbad++;
            $display("FAIL %s: got=%b want=%b", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every output change of any instance consumes one expectation.
    always @(negedge CLK) begin
        cur[0] = {err0, BUSY0, CP0, ACKOUT0, SENDOUT0};
        cur[1] = {err1, BUSY1, CP1, ACKOUT1, 2'b00, SENDOUT1};
        cur[2] = {err2, BUSY2, CP2, ACKOUT2, 1'b0, SENDOUT2};
        for (int k = 0; k < 3; k++) begin
            if (mon_en && (cur[k] !== prev[k])) begin
                nchk++;
                if (sbq.size() == 0) begin
                    nbad++;
                    $display("FAIL unexpected: u%0d cyc=%0d got=%b",
                             k, cyc, cur[k]);
                end else begin
                    me = sbq.pop_front();
                    if (me.k != k || me.cyc != cyc || me.v !== cur[k]) begin
                        nbad++;
                        $display("FAIL %s: got u%0d cyc=%0d val=%b want u%0d cyc=%0d val=%b",
                                 me.nm, k, cyc, cur[k], me.k, me.cyc, me.v);
                    end
                end
            end
            prev[k] = cur[k];
        end
    end

    logic [1:0] obr[2];
    logic [3:0] oso[2];
    int t0;

    initial begin
        RESET = 1'b1;
        SENDIN0 = 1'b0; BRIN0 = 2'd0; LOPEN0 = 1'b1; ACKIN0 = 4'b0;
        auto1 = 1'b0; BRIN1 = 1'b0; LOPEN1 = 1'b1;
        SENDIN2 = 1'b0; BRIN2 = 2'd0; LOPEN2 = 1'b1; ACKIN2 = 3'b0;
        repeat (2) tick();
        chk("rst_u0", {err0, BUSY0, CP0, ACKOUT0, SENDOUT0}, 8'h00);
        chk("rst_u1", {err1, BUSY1, CP1, ACKOUT1, 2'b00, SENDOUT1}, 8'h00);
        chk("rst_u2", {err2, BUSY2, CP2, ACKOUT2, 1'b0, SENDOUT2}, 8'h00);
        RESET = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();

        // basic routing, BRIN changed after acceptance
        SENDIN0 = 1'b1; BRIN0 = 2'd2; t0 = cyc + 1;
        push(0, t0, sv(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000), "b_cp");
        push(0, t0 + 1, sv(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000), "b_cpfall");
        push(0, t0 + 2, sv(1'b0, 1'b1, 1'b0, 1'b0, 4'b0100), "b_send");
        tick(); BRIN0 = 2'd1;
        tick(); tick();
        ACKIN0 = 4'b0100;
        push(0, t0 + 3, sv(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000), "b_ack");
        tick(); SENDIN0 = 1'b0; ACKIN0 = 4'b0;
        push(0, t0 + 4, 8'h00, "b_idle");
        repeat (2) tick();

        // asynchronous reset in SEND
        SENDIN0 = 1'b1; BRIN0 = 2'd3; t0 = cyc + 1;
        push(0, t0, sv(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000), "r_cp");
        push(0, t0 + 1, sv(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000), "r_dly");
        push(0, t0 + 2, sv(1'b0, 1'b1, 1'b0, 1'b0, 4'b1000), "r_send");
        repeat (4) tick();
        RESET = 1'b1; SENDIN0 = 1'b0;
        push(0, t0 + 3, 8'h00, "r_async");
        repeat (2) tick();
        RESET = 1'b0;
        repeat (3) tick();
        chk("r_after", {err0, BUSY0, CP0, ACKOUT0, SENDOUT0}, 8'h00);

        // zero delay, back-to-back tokens with alternating routes
        for (int k = 0; k < 50; k++) begin
            BRIN1 = (k % 2 == 0) ? 1'b1 : 1'b0;
            auto1 = 1'b1;
            t0 = cyc + 1;
            push(1, t0, sv(1'b0, 1'b1, 1'b1, 1'b0,
                           (k % 2 == 0) ? 4'b0010 : 4'b0001), "z_cp");
            push(1, t0 + 1, sv(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000), "z_ack");
            push(1, t0 + 2, 8'h00, "z_idle");
            repeat (3) tick();
        end
        auto1 = 1'b0;
        repeat (2) tick();

        // LOPEN stall in DELAY and in SEND
        SENDIN0 = 1'b1; BRIN0 = 2'd1; t0 = cyc + 1;
        push(0, t0, sv(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000), "l_cp");
        push(0, t0 + 1, sv(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000), "l_hold");
        tick(); LOPEN0 = 1'b0;
        repeat (5) tick();
        LOPEN0 = 1'b1;
        push(0, t0 + 7, sv(1'b0, 1'b1, 1'b0, 1'b0, 4'b0010), "l_send");
        repeat (2) tick();
        LOPEN0 = 1'b0; ACKIN0 = 4'b0010;
        push(0, t0 + 8, sv(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000), "l_mask");
        repeat (5) tick();
        LOPEN0 = 1'b1;
        push(0, t0 + 13, sv(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000), "l_ack");
        tick(); SENDIN0 = 1'b0; ACKIN0 = 4'b0;
        push(0, t0 + 14, 8'h00, "l_idle");
        repeat (3) tick();

        // wrong-channel acknowledge
        SENDIN0 = 1'b1; BRIN0 = 2'd0; t0 = cyc + 1;
        push(0, t0, sv(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000), "w_cp");
        push(0, t0 + 1, sv(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000), "w_dly");
        push(0, t0 + 2, sv(1'b0, 1'b1, 1'b0, 1'b0, 4'b0001), "w_send");
        repeat (3) tick();
        ACKIN0 = 4'b0010;
        if (PC) push(0, t0 + 3, sv(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001), "w_err");
        tick(); ACKIN0 = 4'b0;
        tick(); ACKIN0 = 4'b0001;
        push(0, t0 + 5, sv(PC, 1'b1, 1'b0, 1'b1, 4'b0000), "w_ack");
        tick(); SENDIN0 = 1'b0; ACKIN0 = 4'b0;
        push(0, t0 + 6, sv(PC, 1'b0, 1'b0, 1'b0, 4'b0000), "w_idle");
        repeat (2) tick();
        chk("w_sticky", {err0, BUSY0, CP0, ACKOUT0, SENDOUT0},
            sv(PC, 1'b0, 1'b0, 1'b0, 4'b0000));
        RESET = 1'b1;
        if (PC) push(0, t0 + 7, 8'h00, "w_clr");
        repeat (2) tick();
        RESET = 1'b0;
        tick();
        chk("w_rst", {err0, BUSY0, CP0, ACKOUT0, SENDOUT0}, 8'h00);

        // out-of-range select saturates, then an in-range token
        obr[0] = 2'd3; oso[0] = 4'b0100;
        obr[1] = 2'd1; oso[1] = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            SENDIN2 = 1'b1; BRIN2 = obr[i]; t0 = cyc + 1;
            push(2, t0, sv(PC, 1'b1, 1'b1, 1'b0, 4'b0000), "o_cp");
            push(2, t0 + 1, sv(PC, 1'b1, 1'b0, 1'b0, oso[i]), "o_send");
            repeat (2) tick();
            ACKIN2 = oso[i][2:0];
            push(2, t0 + 2, sv(PC, 1'b1, 1'b0, 1'b1, 4'b0000), "o_ack");
            tick(); SENDIN2 = 1'b0; ACKIN2 = 3'b0;
            push(2, t0 + 3, sv(PC, 1'b0, 1'b0, 1'b0, 4'b0000), "o_idle");
            repeat (2) tick();
        end

        repeat (4) tick();
        while (sbq.size() > 0) begin
            me = sbq.pop_front();
            nchk++;
            nbad++;
            $display("FAIL %s: no change seen, want u%0d cyc=%0d val=%b",
                     me.nm, me.k, me.cyc, me.v);
        end
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
